// File: rtl/mem_tagged_pipe.sv
// mem_tagged_pipe: unified 64-bit-line memory with a tag pool and fixed-latency
// in-order completion. One load or store can be accepted per cycle, and up to
// NUM_TAGS requests can be in flight. Misaligned and out-of-range requests are
// rejected with a one-cycle error pulse.
module mem_tagged_pipe #(
  parameter int LINES    = 8192,
  parameter int LATENCY  = 4,
  parameter int NUM_TAGS = 15,
  parameter int XLEN     = 32
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [1:0]      proc2mem_command,
  input  logic [XLEN-1:0] proc2mem_addr,
  input  logic [63:0]     proc2mem_data,
  input  logic [1:0]      proc2mem_size,
  output logic [3:0]      mem2proc_response,
  output logic [63:0]     mem2proc_data,
  output logic [3:0]      mem2proc_tag,
  output logic            mem_error,
  output logic [4:0]      outstanding
);

  localparam int IDX_W = (LINES > 1) ? $clog2(LINES) : 1;
  // Size of the memory in bytes. One extra bit keeps the comparison exact for
  // a memory that fills the whole address space.
  localparam logic [XLEN:0] MEM_BYTES = (XLEN+1)'(LINES) << 3;

  // Backing store. It has no reset so that preloaded contents survive.
  logic [63:0] unified_memory [0:LINES-1];

  // In the pipeline, tag 0 marks an empty slot and store slots carry zero
  // data. This lets the last stage drive the outputs directly.
  logic [3:0]  pipe_tag_reg  [0:LATENCY-1];
  logic [63:0] pipe_data_reg [0:LATENCY-1];

  logic [NUM_TAGS:1] alloc_reg;
  logic [NUM_TAGS:1] alloc_next;
  logic [4:0]        outstanding_reg;
  logic [4:0]        outstanding_next;
  logic              mem_error_reg;

  logic             is_load;
  logic             is_store;
  logic             is_req;
  logic             in_range;
  logic             aligned;
  logic             accept;
  logic [2:0]       offset;
  logic [IDX_W-1:0] line_idx;
  logic [3:0]       free_tag;
  logic [3:0]       done_tag;
  logic [7:0]       size_be;
  logic [63:0]      size_mask;
  logic [7:0]       wr_be;
  logic [63:0]      wr_data;
  logic [63:0]      rd_line;
  logic [63:0]      ld_data;

  assign is_load  = (proc2mem_command == 2'd1);
  assign is_store = (proc2mem_command == 2'd2);
  assign is_req   = is_load | is_store;
  assign in_range = ({1'b0, proc2mem_addr} < MEM_BYTES);
  assign offset   = proc2mem_addr[2:0];
  assign line_idx = proc2mem_addr[3 +: IDX_W];
  assign done_tag = pipe_tag_reg[LATENCY-1];

  // Alignment check and lane masks for the access size.
  always_comb begin
    aligned   = 1'b1;
    size_be   = 8'h01;
    size_mask = 64'h0000_0000_0000_00FF;
    case (proc2mem_size)
      2'd0: begin
        aligned   = 1'b1;
        size_be   = 8'h01;
        size_mask = 64'h0000_0000_0000_00FF;
      end
      2'd1: begin
        aligned   = (proc2mem_addr[0] == 1'b0);
        size_be   = 8'h03;
        size_mask = 64'h0000_0000_0000_FFFF;
      end
      2'd2: begin
        aligned   = (proc2mem_addr[1:0] == 2'b00);
        size_be   = 8'h0F;
        size_mask = 64'h0000_0000_FFFF_FFFF;
      end
      default: begin
        aligned   = (proc2mem_addr[2:0] == 3'b000);
        size_be   = 8'hFF;
        size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
      end
    endcase
  end

  // Find the lowest-numbered free tag. The result is 0 when the pool is dry.
  always_comb begin
    free_tag = 4'd0;
    for (int i = NUM_TAGS; i >= 1; i--) begin
      if (!alloc_reg[i]) free_tag = 4'(i);
    end
  end

  // Reset gates acceptance, so the response is also 0 while reset_n is low.
  assign accept            = reset_n & is_req & in_range & aligned & (free_tag != 4'd0);
  assign mem2proc_response = accept ? free_tag : 4'd0;

  // Loads read the line as it was before any same-cycle store is applied.
  assign rd_line = unified_memory[line_idx];
  assign ld_data = (rd_line >> {offset, 3'b000}) & size_mask;
  assign wr_be   = size_be << offset;
  assign wr_data = proc2mem_data << {offset, 3'b000};

  // Byte-enabled store into the addressed line.
  always_ff @(posedge clock) begin
    if (accept && is_store) begin
      for (int b = 0; b < 8; b++) begin
        if (wr_be[b]) unified_memory[line_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  // Tag allocation. A completing tag stays busy through its completion cycle.
  // Because of this, the tag being retired is never handed out again in the
  // same cycle.
  for (genvar gi = 1; gi <= NUM_TAGS; gi++) begin : g_tag
    assign alloc_next[gi] = (alloc_reg[gi] & (done_tag != 4'(gi)))
                          | (mem2proc_response == 4'(gi));
  end

  assign outstanding_next = outstanding_reg
                          + 5'(accept)
                          - 5'(done_tag != 4'd0);

  // Tag pool, occupancy count and error pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      alloc_reg       <= '0;
      outstanding_reg <= 5'd0;
      mem_error_reg   <= 1'b0;
    end else begin
      alloc_reg       <= alloc_next;
      outstanding_reg <= outstanding_next;
      mem_error_reg   <= is_req & ~(in_range & aligned);
    end
  end

  // Completion shift register. Stage 0 is loaded at the accepting edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < LATENCY; s++) begin
        pipe_tag_reg[s]  <= 4'd0;
        pipe_data_reg[s] <= 64'd0;
      end
    end else begin
      pipe_tag_reg[0]  <= mem2proc_response;
      pipe_data_reg[0] <= (accept && is_load) ? ld_data : 64'd0;
      for (int s = 1; s < LATENCY; s++) begin
        pipe_tag_reg[s]  <= pipe_tag_reg[s-1];
        pipe_data_reg[s] <= pipe_data_reg[s-1];
      end
    end
  end

  assign mem2proc_tag  = pipe_tag_reg[LATENCY-1];
  assign mem2proc_data = pipe_data_reg[LATENCY-1];
  assign mem_error     = mem_error_reg;
  assign outstanding   = outstanding_reg;

endmodule

// File: tb/tb_mem_tagged_pipe.sv
// Scoreboard bench for mem_tagged_pipe. Instance a uses the default
// parameters. Instance b has a two-tag pool, which exercises backpressure.
`timescale 1ns/1ns
module tb_mem_tagged_pipe;

  localparam int LAT = 4;
  localparam logic [1:0] NONE = 2'd0, LOAD = 2'd1, STORE = 2'd2;
  localparam logic [1:0] SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2, SZ_D = 2'd3;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic [1:0]  cmd_a = NONE, size_a = SZ_D, cmd_b = NONE, size_b = SZ_D;
  logic [31:0] addr_a = '0, addr_b = '0;
  logic [63:0] wdata_a = '0, wdata_b = '0;
  logic [3:0]  resp_a, tag_a, resp_b, tag_b;
  logic [63:0] rdata_a, rdata_b;
  logic        err_a, err_b;
  logic [4:0]  outst_a, outst_b;

  mem_tagged_pipe dut_a (
    .clock(clock), .reset_n(reset_n),
    .proc2mem_command(cmd_a), .proc2mem_addr(addr_a),
    .proc2mem_data(wdata_a), .proc2mem_size(size_a),
    .mem2proc_response(resp_a), .mem2proc_data(rdata_a),
    .mem2proc_tag(tag_a), .mem_error(err_a), .outstanding(outst_a)
  );

  mem_tagged_pipe #(.NUM_TAGS(2)) dut_b (
    .clock(clock), .reset_n(reset_n),
    .proc2mem_command(cmd_b), .proc2mem_addr(addr_b),
    .proc2mem_data(wdata_b), .proc2mem_size(size_b),
    .mem2proc_response(resp_b), .mem2proc_data(rdata_b),
    .mem2proc_tag(tag_b), .mem_error(err_b), .outstanding(outst_b)
  );

  typedef struct {
    int          which;
    logic [3:0]  tag;
    logic [63:0] data;
    int          issue;
    int          due;
  } comp_t;

  typedef struct {
    int which;
    int due;
  } err_t;

  comp_t sb[$];
  err_t  errq[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one request for a cycle and check the combinational response. The
  // expected completion and the expected error pulse go to the scoreboard.
  task automatic issue(input int w, input logic [1:0] cmd, input logic [31:0] addr,
                       input logic [63:0] data, input logic [1:0] size,
                       input logic [3:0] exp_resp, input logic exp_err,
                       input logic [63:0] exp_rdata);
    logic [3:0] r;
    @(posedge clock);
    #1;
    cmd_a = NONE;
    cmd_b = NONE;
    if (w == 0) begin
      cmd_a = cmd; addr_a = addr; wdata_a = data; size_a = size;
    end else begin
      cmd_b = cmd; addr_b = addr; wdata_b = data; size_b = size;
    end
    @(negedge clock);
    r = (w == 0) ? resp_a : resp_b;
    $display("cycle %0d dut%0d cmd=%0d addr=%h size=%0d wdata=%h -> response %0d",
             cyc, w, cmd, addr, size, data, r);
    check("response", 64'(r), 64'(exp_resp));
    if (exp_resp != 4'd0) sb.push_back(comp_t'{w, exp_resp, exp_rdata, cyc, cyc + LAT});
    if (exp_err) errq.push_back(err_t'{w, cyc + 1});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
      cmd_a = NONE;
      cmd_b = NONE;
    end
  endtask

  // Per-cycle check of one instance: occupancy, error pulse and completion.
  task automatic mon(input int w, input logic [3:0] tag, input logic [63:0] data,
                     input logic err, input logic [4:0] outst);
    int   exp_out;
    int   idx;
    logic exp_err;
    exp_out = 0;
    foreach (sb[i]) begin
      if (sb[i].which == w && sb[i].issue < cyc && sb[i].due >= cyc) exp_out++;
    end
    check($sformatf("outstanding dut%0d", w), 64'(outst), 64'(exp_out));
    exp_err = 1'b0;
    for (int i = 0; i < errq.size(); i++) begin
      if (errq[i].which == w && errq[i].due == cyc) begin
        exp_err = 1'b1;
        errq.delete(i);
        break;
      end
    end
    check($sformatf("mem_error dut%0d", w), 64'(err), 64'(exp_err));
    idx = -1;
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].which == w) begin
        idx = i;
        break;
      end
    end
    if (idx >= 0 && sb[idx].due == cyc) begin
      $display("cycle %0d dut%0d completion tag=%0d data=%h", cyc, w, tag, data);
      check($sformatf("completion tag dut%0d", w), 64'(tag), 64'(sb[idx].tag));
      check($sformatf("completion data dut%0d", w), data, sb[idx].data);
      sb.delete(idx);
    end else if (tag != 4'd0) begin
      check($sformatf("unexpected completion dut%0d", w), 64'(tag), 64'd0);
    end
  endtask

  initial begin
    forever begin
      @(negedge clock);
      if (reset_n) begin
        mon(0, tag_a, rdata_a, err_a, outst_a);
        mon(1, tag_b, rdata_b, err_b, outst_b);
      end
    end
  end

  initial begin
    // Reset state.
    #1 reset_n = 1'b0;
    #1;
    check("reset tag", 64'(tag_a), 64'd0);
    check("reset data", rdata_a, 64'd0);
    check("reset error", 64'(err_a), 64'd0);
    check("reset outstanding", 64'(outst_a), 64'd0);
    repeat (2) @(posedge clock);
    #3 reset_n = 1'b1;

    // Preload line 2, then read it back as a double.
    issue(0, STORE, 32'h10, 64'h1122334455667788, SZ_D, 4'd1, 1'b0, 64'd0);
    idle(4);
    issue(0, LOAD, 32'h10, 64'd0, SZ_D, 4'd1, 1'b0, 64'h1122334455667788);
    idle(4);

    // Half store followed directly by a double load of the same line.
    issue(0, STORE, 32'h12, 64'hBEEF, SZ_H, 4'd1, 1'b0, 64'd0);
    issue(0, LOAD, 32'h10, 64'd0, SZ_D, 4'd2, 1'b0, 64'h11223344BEEF7788);
    idle(4);

    // Misaligned and out-of-range requests.
    issue(0, LOAD, 32'h06, 64'd0, SZ_W, 4'd0, 1'b1, 64'd0);
    issue(0, LOAD, 32'd65536, 64'd0, SZ_D, 4'd0, 1'b1, 64'd0);
    issue(0, STORE, 32'h13, 64'h1234, SZ_H, 4'd0, 1'b1, 64'd0);
    idle(2);

    // Sub-word accesses. Tag 1 is reused once its completion has retired.
    issue(0, STORE, 32'h10, 64'hAB00000000000000, SZ_D, 4'd1, 1'b0, 64'd0);
    issue(0, LOAD, 32'h17, 64'd0, SZ_B, 4'd2, 1'b0, 64'h00000000000000AB);
    issue(0, LOAD, 32'h16, 64'd0, SZ_H, 4'd3, 1'b0, 64'h000000000000AB00);
    issue(0, STORE, 32'h11, 64'h55, SZ_B, 4'd4, 1'b0, 64'd0);
    issue(0, LOAD, 32'h10, 64'd0, SZ_D, 4'd5, 1'b0, 64'hAB00000000005500);
    issue(0, LOAD, 32'h14, 64'd0, SZ_W, 4'd1, 1'b0, 64'h00000000AB000000);
    idle(5);

    // Two-tag pool: loads every cycle run the pool dry until tags retire.
    issue(1, STORE, 32'h0, 64'h0123456789ABCDEF, SZ_D, 4'd1, 1'b0, 64'd0);
    idle(4);
    issue(1, LOAD, 32'h0, 64'd0, SZ_D, 4'd1, 1'b0, 64'h0123456789ABCDEF);
    issue(1, LOAD, 32'h0, 64'd0, SZ_D, 4'd2, 1'b0, 64'h0123456789ABCDEF);
    issue(1, LOAD, 32'h0, 64'd0, SZ_D, 4'd0, 1'b0, 64'd0);
    issue(1, LOAD, 32'h0, 64'd0, SZ_D, 4'd0, 1'b0, 64'd0);
    issue(1, LOAD, 32'h0, 64'd0, SZ_D, 4'd0, 1'b0, 64'd0);
    issue(1, LOAD, 32'h0, 64'd0, SZ_D, 4'd1, 1'b0, 64'h0123456789ABCDEF);
    issue(1, LOAD, 32'h0, 64'd0, SZ_D, 4'd2, 1'b0, 64'h0123456789ABCDEF);
    idle(6);

    // Three loads in flight, then reset pulsed low in the middle of a cycle.
    issue(0, LOAD, 32'h10, 64'd0, SZ_D, 4'd1, 1'b0, 64'hAB00000000005500);
    issue(0, LOAD, 32'h10, 64'd0, SZ_D, 4'd2, 1'b0, 64'hAB00000000005500);
    issue(0, LOAD, 32'h10, 64'd0, SZ_D, 4'd3, 1'b0, 64'hAB00000000005500);
    @(posedge clock);
    #1;
    cmd_a = LOAD; addr_a = 32'h10; size_a = SZ_D;
    #1 reset_n = 1'b0;
    #1;
    $display("cycle %0d reset pulse with loads in flight", cyc);
    check("mid reset tag", 64'(tag_a), 64'd0);
    check("mid reset outstanding", 64'(outst_a), 64'd0);
    check("mid reset response", 64'(resp_a), 64'd0);
    check("mid reset data", rdata_a, 64'd0);
    sb.delete();
    errq.delete();
    cmd_a = NONE;
    #1 reset_n = 1'b1;

    // The pool restarts at tag 1 and memory contents survive the reset.
    issue(0, LOAD, 32'h10, 64'd0, SZ_D, 4'd1, 1'b0, 64'hAB00000000005500);
    issue(0, LOAD, 32'h17, 64'd0, SZ_B, 4'd2, 1'b0, 64'h00000000000000AB);
    idle(6);

    check("scoreboard drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
